// File: rtl/gol_gen_scheduler_if.sv
// Control/data bundle for the Game of Life generation scheduler.
// master: drives frame_tick, run, step, load, seed; observes board and status.
// slave : the scheduler; receives the controls and drives board, busy,
//         gen_done and gen_count.
interface gol_gen_scheduler_if;
   logic         frame_tick;
   logic         run;
   logic         step;
   logic         load;
   logic [255:0] seed;
   logic [255:0] board;
   logic         busy;
   logic         gen_done;
   logic [15:0]  gen_count;

   modport master (
      output frame_tick, run, step, load, seed,
      input  board, busy, gen_done, gen_count
   );

   modport slave (
      input  frame_tick, run, step, load, seed,
      output board, busy, gen_done, gen_count
   );
endinterface

// File: rtl/gol_gen_scheduler.sv
// Game of Life generation scheduler for a 16x16 toroidal board.
// Starts a generation on step, or in run mode every FRAMES_PER_GEN frame_ticks.
// It then evaluates one cell per cycle into next_board and commits the whole
// board in a single cycle, so the displayed board never tears.
// Ports: clk, rst (async, active-high), bus (gol_gen_scheduler_if.slave):
//   frame_tick/run/step/load/seed in; board/busy/gen_done/gen_count out.
// Cell index i maps to row i[7:4], column i[3:0].
module gol_gen_scheduler #(
   parameter int unsigned FRAMES_PER_GEN = 30
) (
   input  logic                  clk,
   input  logic                  rst,
   gol_gen_scheduler_if.slave    bus
);

   localparam int unsigned CELLS_W = 256;
   localparam int unsigned IDX_W   = 8;
   localparam int unsigned GEN_W   = 16;
   localparam logic [IDX_W-1:0] FRAME_LAST = IDX_W'(FRAMES_PER_GEN - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(CELLS_W - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      COMMIT  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CELLS_W-1:0] board_q, next_board_q;
   logic [GEN_W-1:0]   gen_count_q;
   logic [IDX_W-1:0]   frame_cnt_q;
   logic [IDX_W-1:0]   idx_q;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               frame_hit_c;
   logic               trig_c;
   logic [3:0]         row_c, col_c, rn_c, rs_c, cw_c, ce_c;
   logic [3:0]         nbr_c;
   logic               life_c;

   // Frame trigger fires on the tick that completes the current frame period.
   assign frame_hit_c = bus.frame_tick && bus.run && (frame_cnt_q == FRAME_LAST);
   assign trig_c      = bus.step || frame_hit_c;

   // Neighbour count of the current cell; 4-bit arithmetic gives the torus wrap.
   always_comb begin
      row_c = idx_q[7:4];
      col_c = idx_q[3:0];
      rn_c  = row_c - 4'd1;
      rs_c  = row_c + 4'd1;
      cw_c  = col_c - 4'd1;
      ce_c  = col_c + 4'd1;
      nbr_c = 4'(board_q[{rn_c, cw_c}]) + 4'(board_q[{rn_c, col_c}]) +
              4'(board_q[{rn_c, ce_c}]) + 4'(board_q[{row_c, cw_c}]) +
              4'(board_q[{row_c, ce_c}]) + 4'(board_q[{rs_c, cw_c}]) +
              4'(board_q[{rs_c, col_c}]) + 4'(board_q[{rs_c, ce_c}]);
      life_c = (nbr_c == 4'd3) || (board_q[idx_q] && (nbr_c == 4'd2));
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; load overrides everything and aborts any generation.
   always_comb begin
      state_d = state_q;
      if (bus.load) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:    if (trig_c) state_d = COMPUTE;
            COMPUTE: if (idx_q == IDX_LAST) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Output decode; registered below so busy tracks the state exactly.
   always_comb begin
      busy_d = 1'b0;
      done_d = 1'b0;
      busy_d = (state_d != IDLE);
      done_d = (state_q == COMMIT) && !bus.load;
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         board_q      <= '0;
         next_board_q <= '0;
         gen_count_q  <= '0;
         frame_cnt_q  <= '0;
         idx_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         busy_q <= busy_d;
         done_q <= done_d;
         if (bus.load) begin
            board_q     <= bus.seed;
            gen_count_q <= '0;
            frame_cnt_q <= '0;
            idx_q       <= '0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  idx_q <= '0;
                  if (bus.frame_tick && bus.run) begin
                     if (frame_cnt_q == FRAME_LAST) frame_cnt_q <= '0;
                     else                           frame_cnt_q <= frame_cnt_q + 8'd1;
                  end
               end
               COMPUTE: begin
                  next_board_q[idx_q] <= life_c;
                  idx_q               <= idx_q + 8'd1;
               end
               COMMIT: begin
                  board_q     <= next_board_q;
                  gen_count_q <= gen_count_q + 16'd1;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.board     = board_q;
   assign bus.busy      = busy_q;
   assign bus.gen_done  = done_q;
   assign bus.gen_count = gen_count_q;

endmodule

// File: tb/tb_gol_gen_scheduler.sv
// Scoreboard bench for gol_gen_scheduler: stimulus pushes expected commits
// (board, gen_count, cycle of gen_done); a negedge monitor pops and compares.
module tb_gol_gen_scheduler;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   typedef struct {
      logic [255:0] board;
      logic [15:0]  cnt;
      int           cyc;
   } exp_t;

   exp_t exp_q[$];

   gol_gen_scheduler_if bus();

   gol_gen_scheduler #(.FRAMES_PER_GEN(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h required %h", name, act, req);
   endtask

   // Monitor: every gen_done must match the oldest expected commit.
   always @(negedge clk) begin
      if (bus.gen_done === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_gen_done_cycle", 256'(cyc), 256'(0));
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("commit_board", bus.board, e.board);
            chk("commit_gen_count", 256'(bus.gen_count), 256'(e.cnt));
            chk("commit_latency_cycle", 256'(cyc), 256'(e.cyc));
         end
      end
   end

   task automatic cyc_wait(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_load(input logic [255:0] s);
      bus.seed = s;
      bus.load = 1'b1;
      cyc_wait(1);
      bus.load = 1'b0;
   endtask

   task automatic push_exp(input logic [255:0] b, input logic [15:0] c);
      exp_t e;
      e.board = b;
      e.cnt   = c;
      e.cyc   = cyc + 258;
      exp_q.push_back(e);
   endtask

   task automatic do_step(input logic [255:0] b, input logic [15:0] c);
      bus.step = 1'b1;
      push_exp(b, c);
      cyc_wait(1);
      bus.step = 1'b0;
   endtask

   task automatic drain(input int budget);
      int b;
      b = 0;
      while (exp_q.size() != 0 && b < budget) begin
         cyc_wait(1);
         b++;
      end
      if (exp_q.size() != 0) begin
         chk("drain_timeout_pending", 256'(exp_q.size()), 256'(0));
         exp_q.delete();
      end
   endtask

   logic [255:0] blink_h, blink_v, corners;

   initial begin
      blink_h = '0;
      blink_h[8'h12] = 1'b1; blink_h[8'h13] = 1'b1; blink_h[8'h14] = 1'b1;
      blink_v = '0;
      blink_v[8'h03] = 1'b1; blink_v[8'h13] = 1'b1; blink_v[8'h23] = 1'b1;
      corners = '0;
      corners[8'h00] = 1'b1; corners[8'h0F] = 1'b1;
      corners[8'hF0] = 1'b1; corners[8'hFF] = 1'b1;

      bus.frame_tick = 1'b0;
      bus.run        = 1'b0;
      bus.step       = 1'b0;
      bus.load       = 1'b0;
      bus.seed       = '0;

      // Reset state
      cyc_wait(3);
      chk("rst_board", bus.board, '0);
      chk("rst_busy", 256'(bus.busy), 256'(0));
      chk("rst_gen_done", 256'(bus.gen_done), 256'(0));
      chk("rst_gen_count", 256'(bus.gen_count), 256'(0));
      rst = 1'b0;
      cyc_wait(2);

      // Blinker, single step
      pulse_load(blink_h);
      chk("load_board", bus.board, blink_h);
      do_step(blink_v, 16'd1);
      chk("busy_after_trigger", 256'(bus.busy), 256'(1));
      cyc_wait(100);
      chk("board_stable_in_compute", bus.board, blink_h);
      drain(400);
      cyc_wait(2);
      chk("blinker_busy_idle", 256'(bus.busy), 256'(0));
      chk("blinker_gen_count", 256'(bus.gen_count), 256'(1));

      // Still-life block across the corners
      pulse_load(corners);
      chk("wrap_load_clears_count", 256'(bus.gen_count), 256'(0));
      do_step(corners, 16'd1);
      drain(400);

      // Second step while busy is dropped
      pulse_load(blink_h);
      do_step(blink_v, 16'd1);
      cyc_wait(9);
      bus.step = 1'b1;
      cyc_wait(1);
      bus.step = 1'b0;
      drain(400);
      cyc_wait(300);
      chk("ignore_busy_gen_count", 256'(bus.gen_count), 256'(1));

      // Load aborts a generation in progress
      pulse_load(blink_h);
      bus.step = 1'b1;
      cyc_wait(1);
      bus.step = 1'b0;
      cyc_wait(100);
      chk("abort_busy_before", 256'(bus.busy), 256'(1));
      pulse_load(corners);
      chk("abort_board", bus.board, corners);
      chk("abort_gen_count", 256'(bus.gen_count), 256'(0));
      chk("abort_busy", 256'(bus.busy), 256'(0));
      cyc_wait(300);

      // Reset in the middle of a generation
      pulse_load(blink_h);
      bus.step = 1'b1;
      cyc_wait(1);
      bus.step = 1'b0;
      cyc_wait(50);
      rst = 1'b1;
      #1;
      chk("midrst_board_async", bus.board, '0);
      chk("midrst_busy_async", 256'(bus.busy), 256'(0));
      cyc_wait(2);
      rst = 1'b0;
      cyc_wait(300);
      chk("midrst_busy_after", 256'(bus.busy), 256'(0));
      chk("midrst_gen_count", 256'(bus.gen_count), 256'(0));

      // Run pacing with FRAMES_PER_GEN=2; run=0 ticks must not count
      pulse_load(blink_h);
      for (int k = 0; k < 3; k++) begin
         bus.frame_tick = 1'b1;
         cyc_wait(1);
         bus.frame_tick = 1'b0;
         cyc_wait(20);
      end
      bus.run = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         bus.frame_tick = 1'b1;
         if (k == 2) push_exp(blink_v, 16'd1);
         if (k == 4) push_exp(blink_h, 16'd2);
         if (k == 6) push_exp(blink_v, 16'd3);
         cyc_wait(1);
         bus.frame_tick = 1'b0;
         cyc_wait(299);
      end
      drain(400);
      chk("run_gen_count", 256'(bus.gen_count), 256'(3));

      // Step and frame trigger together start one generation
      bus.frame_tick = 1'b1;
      cyc_wait(1);
      bus.frame_tick = 1'b0;
      cyc_wait(299);
      bus.frame_tick = 1'b1;
      bus.step = 1'b1;
      push_exp(blink_h, 16'd4);
      cyc_wait(1);
      bus.frame_tick = 1'b0;
      bus.step = 1'b0;
      drain(400);
      cyc_wait(300);
      chk("coincident_gen_count", 256'(bus.gen_count), 256'(4));
      bus.run = 1'b0;

      // Load coincident with step: load only
      bus.seed = blink_v;
      bus.load = 1'b1;
      bus.step = 1'b1;
      cyc_wait(1);
      bus.load = 1'b0;
      bus.step = 1'b0;
      chk("load_step_busy", 256'(bus.busy), 256'(0));
      chk("load_step_board", bus.board, blink_v);
      chk("load_step_gen_count", 256'(bus.gen_count), 256'(0));
      cyc_wait(300);
      chk("load_step_pending", 256'(exp_q.size()), 256'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/gol_gen_scheduler.md
GOL_GEN_SCHEDULER -- requirements
Module: gol_gen_scheduler

Interface
REQ-001 The block SHALL have parameter FRAMES_PER_GEN, default 30: frame_tick pulses per generation in run mode, legal range 1..255.
REQ-002 Port clk, input, 1: the single system clock; all state SHALL change only on its rising edge, except on reset.
REQ-003 Port rst, input, 1: asynchronous, active-high reset.
REQ-004 Port frame_tick, input, 1: one-cycle pulse at vertical blank start.
REQ-005 Port run, input, 1: level; 1 SHALL mean generations advance automatically.
REQ-006 Port step, input, 1: one-cycle pulse requesting a single generation.
REQ-007 Port load, input, 1: one-cycle pulse that replaces the board with seed.
REQ-008 Port seed, input, 256: initial pattern; bit i is row i[7:4], column i[3:0].
REQ-009 Port board, output, 256: the committed, display-stable board, with the same indexing as seed.
REQ-010 Port busy, output, 1: 1 while a generation is being computed.
REQ-011 Port gen_done, output, 1: one-cycle pulse when a new board is committed.
REQ-012 Port gen_count, output, 16: number of generations since the last load or reset.

Function
REQ-013 The FSM SHALL have three states: IDLE, COMPUTE and COMMIT.
REQ-014 frame_cnt, 8 bits, SHALL increment on frame_tick only in IDLE with run=1; it SHALL hold its value when run=0.
REQ-015 The IDLE->COMPUTE trigger SHALL be either of:
- frame_tick with run=1 and frame_cnt==FRAMES_PER_GEN-1; frame_cnt SHALL then clear to 0.
- step=1, regardless of run.
REQ-016 If the step trigger and the frame trigger occur in the same cycle, the block SHALL start exactly one generation.
REQ-017 COMPUTE SHALL process one cell per cycle at index idx = 0..255, for exactly 256 cycles, then enter COMMIT.
REQ-018 Neighbour count SHALL use the eight cells at (row±1, col±1) mod 16 (toroidal wrap), read from board, never from the partial result.
REQ-019 Next-state rule for each cell:
- next = 1 if the count is 3;
- next = 1 if the cell is alive and the count is 2;
- otherwise next = 0.
The result SHALL be written to next_board[idx].
REQ-020 COMMIT SHALL last one cycle and SHALL:
- copy next_board to board;
- increment gen_count, wrapping 0xFFFF->0;
- pulse gen_done;
- return to IDLE.
REQ-021 board SHALL change only in COMMIT, on load, or on reset; it SHALL be constant throughout COMPUTE.
REQ-022 busy SHALL be 1 in COMPUTE and COMMIT and 0 in IDLE.
REQ-023 A generation from a trigger SHALL take 258 cycles, trigger to gen_done: 1 cycle to enter COMPUTE, 256 in COMPUTE, 1 in COMMIT.
REQ-024 step and frame_tick received while not in IDLE SHALL be ignored and SHALL NOT be queued.
REQ-025 load in any state SHALL have priority over all other inputs and SHALL:
- set board to seed next cycle;
- clear gen_count, frame_cnt and idx;
- force IDLE, aborting any COMPUTE without a gen_done pulse.
REQ-026 load coincident with a trigger in IDLE SHALL perform the load only; no generation SHALL start.
REQ-027 Changes to run SHALL take effect on the next frame_tick, without aborting an active generation.

Reset
REQ-028 While rst=1 the block SHALL immediately hold:
- state=IDLE;
- board=0, next_board=0;
- gen_count=0, frame_cnt=0, idx=0;
- busy=0, gen_done=0.
REQ-029 Reset asserted mid-COMPUTE SHALL discard the partial result; after release the block SHALL wait in IDLE for a trigger.

Verification
REQ-030 Blinker: load seed bits 0x12,0x13,0x14; pulse step -> after 258 cycles, board has bits 0x03,0x13,0x23 only; gen_count=1; gen_done pulses once.
REQ-031 Wrap: load bits 0x00,0x0F,0xF0,0xFF; step -> board is unchanged (a still-life block across the corners); gen_count=1.
REQ-032 Run pacing: FRAMES_PER_GEN=2, run=1, 6 frame_ticks spaced 300 cycles apart -> exactly 3 gen_done pulses, gen_count=3.
REQ-033 Ignore while busy: step, then step again 10 cycles later -> a single gen_done, gen_count=1.
REQ-034 Load abort: step, then load at COMPUTE cycle 100 -> board=seed, gen_count=0, busy=0 next cycle, no gen_done.
REQ-035 Reset mid-compute: rst at COMPUTE cycle 50 -> board=0, busy=0 asynchronously; no gen_done after release.
